// File: rtl/adder_result_collector.sv
// Collects results of the pipelined adder into an in-order FIFO, using credit-based issue control.
// Optional sticky protocol-error output is enabled by defining ADDER_COLLECT_ERR_EN.
module adder_result_collector #(
    parameter int DEPTH   = 8,
    parameter int SUM_LAT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [31:0] adder_sum,
    input  logic        adder_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_cout
`ifdef ADDER_COLLECT_ERR_EN
    ,
    output logic        issue_err
`endif
);

    localparam int DATA_W = 32;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CREDIT_RST = CNT_W'(DEPTH);

    logic [SUM_LAT-1:0] vld_q, vld_d;
    logic               cout_al_q, cout_al_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   credits_q, credits_d;
    logic [DATA_W:0]    mem_q [DEPTH];

    logic accept;
    logic pop;
    logic wr_en;

    assign issue_ready = (credits_q != '0);
    assign accept      = issue_valid && issue_ready;
    assign out_valid   = (count_q != '0);
    assign pop         = out_valid && out_ready;
    assign wr_en       = vld_q[SUM_LAT-1];

    // Head is forced to zero while empty, so outputs are defined without resetting storage.
    assign out_sum  = out_valid ? mem_q[rd_ptr_q][DATA_W-1:0] : '0;
    assign out_cout = out_valid ? mem_q[rd_ptr_q][DATA_W] : 1'b0;

    always_comb begin
        vld_d     = {vld_q[SUM_LAT-2:0], accept};
        cout_al_d = cout_al_q;
        if (vld_q[SUM_LAT-2]) begin
            cout_al_d = adder_cout;
        end

        wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        credits_d = credits_q;
        case ({accept, pop})
            2'b10:   credits_d = credits_q - CNT_ONE;
            2'b01:   credits_d = credits_q + CNT_ONE;
            default: credits_d = credits_q;
        endcase
    end

    // Control stage: delay line, carry alignment, pointers, occupancy and credits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q     <= '0;
            cout_al_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            credits_q <= CREDIT_RST;
        end else begin
            vld_q     <= vld_d;
            cout_al_q <= cout_al_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            credits_q <= credits_d;
        end
    end

    // Storage stage: carry was aligned one cycle earlier, so it pairs with the current sum
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {cout_al_q, adder_sum};
        end
    end

`ifdef ADDER_COLLECT_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (issue_valid && !issue_ready) begin
            err_q <= 1'b1;
        end
    end

    assign issue_err = err_q;
`endif

endmodule

// File: tb/tb_adder_result_collector.sv
// Directed bench for adder_result_collector with a behavioural 5-stage adder model.
// Define ADDER_COLLECT_ERR_EN to also exercise the sticky error output.
module tb_adder_result_collector;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] adder_sum;
    logic        adder_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
`ifdef ADDER_COLLECT_ERR_EN
    logic        issue_err;
`endif

    logic [31:0] op_a, op_b;
    logic        op_cin;
    logic [32:0] pipe [5];

    int checks = 0;
    int errors = 0;

    adder_result_collector #(.DEPTH(8), .SUM_LAT(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout)
`ifdef ADDER_COLLECT_ERR_EN
        ,
        .issue_err  (issue_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: sum sampled 5 edges after operands, carry one edge earlier.
    always @(posedge clk) begin
        pipe[0] <= {1'b0, op_a} + {1'b0, op_b} + {32'd0, op_cin};
        for (int k = 1; k < 5; k++) pipe[k] <= pipe[k-1];
    end
    assign adder_sum  = pipe[4][31:0];
    assign adder_cout = pipe[3][32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] drain_exp [8];

    initial begin
        drain_exp = '{32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107, 32'h200, 32'h201};
        reset = 1'b1; issue_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_cin = 1'b0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_issue_ready", issue_ready, 1);
`ifdef ADDER_COLLECT_ERR_EN
        chk("rst_issue_err", issue_err, 0);
`endif
        reset = 1'b0;
        tick();

        // Single issue: 1 + 0xFFFFFFFF
        op_a = 32'h1; op_b = 32'hFFFF_FFFF; op_cin = 1'b0; issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            tick();
            chk("t1_early_valid", out_valid, 0);
        end
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_sum", out_sum, 32'h0);
        chk("t1_cout", out_cout, 1);
        out_ready = 1'b1;
        tick();
        chk("t1_popped", out_valid, 0);
        chk("t1_credit_back", issue_ready, 1);

        // 16 back-to-back issues with consumer always ready
        for (int c = 0; c < 22; c++) begin
            if (c < 16) chk("t2_ready", issue_ready, 1);
            issue_valid = (c < 16);
            op_a = 32'(c); op_b = 32'h10;
            tick();
            if (c >= 5 && c < 21) begin
                chk("t2_valid", out_valid, 1);
                chk("t2_sum", out_sum, 64'(32'h10 + 32'(c - 5)));
                chk("t2_cout", out_cout, 0);
            end else begin
                chk("t2_idle", out_valid, 0);
            end
        end
        issue_valid = 1'b0;

        // Fill all credits with consumer stalled
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            op_a = 32'h100 + 32'(c); op_b = 32'h0; issue_valid = 1'b1;
            chk("t3_ready", issue_ready, (c < 8) ? 64'd1 : 64'd0);
            tick();
        end
        issue_valid = 1'b0;
`ifdef ADDER_COLLECT_ERR_EN
        chk("t3_err_set", issue_err, 1);
`endif
        tick(); tick(); tick();
        chk("t3_full_valid", out_valid, 1);
        chk("t3_full_head", out_sum, 32'h100);
        chk("t3_full_no_credit", issue_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_credit_restored", issue_ready, 1);
        chk("t3_next_head", out_sum, 32'h101);

        // Pop and accepted issue on the same edge
        op_a = 32'h200; issue_valid = 1'b1; out_ready = 1'b1;
        tick();
        chk("t4_credit_unchanged", issue_ready, 1);
        chk("t4_head", out_sum, 32'h102);
        op_a = 32'h201; out_ready = 1'b0;
        tick();
        issue_valid = 1'b0;
        chk("t4_credits_out", issue_ready, 0);
        repeat (5) tick();
        chk("t4_full_no_credit", issue_ready, 0);
`ifdef ADDER_COLLECT_ERR_EN
        chk("t4_err_sticky", issue_err, 1);
`endif
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("t4_drain_valid", out_valid, 1);
            chk("t4_drain_sum", out_sum, drain_exp[k]);
            tick();
        end
        chk("t4_empty", out_valid, 0);
        chk("t4_ready_after", issue_ready, 1);

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            op_a = 32'h300 + 32'(i); op_b = 32'h0; issue_valid = 1'b1;
            tick();
        end
        issue_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_ready", issue_ready, 1);
`ifdef ADDER_COLLECT_ERR_EN
        chk("t5_rst_err", issue_err, 0);
`endif
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t5_no_stale", out_valid, 0);
        end
        op_a = 32'h5; op_b = 32'h7; issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            tick();
            chk("t5_early_valid", out_valid, 0);
        end
        tick();
        chk("t5_valid", out_valid, 1);
        chk("t5_sum", out_sum, 32'hC);
        chk("t5_cout", out_cout, 0);
        tick();
        chk("t5_popped", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
